// File: rtl/sel_sched_pkg.sv
// Shared types and helpers for the sel_rr_sched round-robin scheduler.
package sel_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Lane index + 1, wrapping n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/sel_rr_pick.sv
// Combinational rotate-priority picker: first requesting lane at or after i_ptr, with wrap.
module sel_rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned SELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic            o_found_c,
    output logic [SELW-1:0] o_idx_c
);

    localparam int unsigned SW1 = SELW + 1;

    logic [SW1-1:0] w_lane;

    always_comb begin
        o_found_c = 1'b0;
        o_idx_c   = '0;
        w_lane    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_lane = {1'b0, i_ptr} + SW1'(i);
            if (w_lane >= SW1'(NREQ)) begin
                w_lane = w_lane - SW1'(NREQ);
            end
            if (!o_found_c && i_req[w_lane[SELW-1:0]]) begin
                o_found_c = 1'b1;
                o_idx_c   = w_lane[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/sel_rr_sched.sv
// Round-robin grant scheduler driving a registered lane index; parks the index when idle.
// Optional SEL_SCHED_LOCK_EN adds a lock input that suppresses the hold timeout.
module sel_rr_sched
    import sel_sched_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned SELW     = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req [NREQ],
    input  logic            done,
`ifdef SEL_SCHED_LOCK_EN
    input  logic            lock,
`endif
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_sel,
    output logic [NREQ-1:0] gnt_onehot
);

    localparam int unsigned          HCW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0]       HOLD_TOP = HCW'(MAX_HOLD - 1);

    state_t          r_state, w_state_nxt;
    logic            r_vld, w_vld_nxt;
    logic [SELW-1:0] r_sel, w_sel_nxt;
    logic [NREQ-1:0] r_onehot, w_onehot_nxt;
    logic [SELW-1:0] r_ptr, w_ptr_nxt;
    logic [HCW-1:0]  r_hold, w_hold_nxt;

    logic [NREQ-1:0] w_req_vec;
    logic            w_found;
    logic [SELW-1:0] w_idx;
    logic            w_timeout;
    logic            w_release;

    always_comb begin
        w_req_vec = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_req_vec[i] = req[i];
        end
    end

    sel_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req     (w_req_vec),
        .i_ptr     (r_ptr),
        .o_found_c (w_found),
        .o_idx_c   (w_idx)
    );

`ifdef SEL_SCHED_LOCK_EN
    assign w_timeout = (r_hold == HOLD_TOP) && !lock;
`else
    assign w_timeout = (r_hold == HOLD_TOP);
`endif
    assign w_release = done || !w_req_vec[r_sel] || w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vld    <= 1'b0;
            r_sel    <= '0;
            r_onehot <= '0;
            r_ptr    <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_vld    <= w_vld_nxt;
            r_sel    <= w_sel_nxt;
            r_onehot <= w_onehot_nxt;
            r_ptr    <= w_ptr_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    // Arbitrate in IDLE/GAP; in GRANT count hold cycles and release on done/withdraw/timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_vld_nxt    = r_vld;
        w_sel_nxt    = r_sel;
        w_onehot_nxt = r_onehot;
        w_ptr_nxt    = r_ptr;
        w_hold_nxt   = r_hold;
        case (r_state)
            IDLE, GAP: begin
                if (w_found) begin
                    w_state_nxt  = GRANT;
                    w_vld_nxt    = 1'b1;
                    w_sel_nxt    = w_idx;
                    w_onehot_nxt = NREQ'(1) << w_idx;
                    w_hold_nxt   = '0;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt  = GAP;
                    w_vld_nxt    = 1'b0;
                    w_onehot_nxt = '0;
                    w_ptr_nxt    = SELW'(wrap_inc(32'(r_sel), NREQ));
                end else if (r_hold != HOLD_TOP) begin
                    w_hold_nxt   = r_hold + HCW'(1);
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_vld_nxt    = 1'b0;
                w_onehot_nxt = '0;
            end
        endcase
    end

    assign gnt_vld    = r_vld;
    assign gnt_sel    = r_sel;
    assign gnt_onehot = r_onehot;

endmodule
